// File: rtl/stream_match_ctrl.sv
// Frames a serial MSB-first bit stream into a 128-bit word and matches it against four keys.
// Optional idle-gap timeout while shifting is enabled by defining STREAM_MATCH_TIMEOUT_EN.
module stream_match_ctrl
`ifdef STREAM_MATCH_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic         in_data,
  input  logic         end_of_sequence,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_match,
  output logic [1:0]   res_index,
  output logic [1:0]   res_error,
  output logic [127:0] res_data
);

  localparam logic [127:0] KEY0 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] KEY1 = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  localparam logic [127:0] KEY2 = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [127:0] KEY3 = 128'h00000000000000000000000000000000;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_SHORT   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    COMPARE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  state_t       state;
  logic [6:0]   bit_cnt;
  logic [127:0] shift_reg;
  logic [1:0]   key_idx;
  logic [127:0] key_sel;
  logic [1:0]   rst_sync;
  logic         rst_int_n;

  // Assert asynchronously, release two clock edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

`ifdef STREAM_MATCH_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap_cnt;
`endif

  always_comb begin
    key_sel = KEY0;
    case (key_idx)
      2'd0: key_sel = KEY0;
      2'd1: key_sel = KEY1;
      2'd2: key_sel = KEY2;
      2'd3: key_sel = KEY3;
      default: key_sel = KEY0;
    endcase
  end

  // Result handshake: res_valid rises on entry to REPORT with all res_* captured
  // in the same edge; they hold until the cycle res_valid & res_ready are both
  // high, after which the controller returns to IDLE on the next edge.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= IDLE;
      bit_cnt   <= 7'd0;
      shift_reg <= 128'd0;
      key_idx   <= 2'd0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_match <= 1'b0;
      res_index <= 2'd0;
      res_error <= ERR_OK;
      res_data  <= 128'd0;
`ifdef STREAM_MATCH_TIMEOUT_EN
      gap_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            bit_cnt   <= 7'd0;
            shift_reg <= 128'd0;
`ifdef STREAM_MATCH_TIMEOUT_EN
            gap_cnt   <= '0;
`endif
          end
        end

        SHIFT: begin
          if (in_valid) begin
            shift_reg <= {shift_reg[126:0], in_data};
            bit_cnt   <= bit_cnt + 7'd1;
`ifdef STREAM_MATCH_TIMEOUT_EN
            gap_cnt   <= '0;
`endif
            if (bit_cnt == 7'd127) begin
              state   <= COMPARE;
              key_idx <= 2'd0;
            end else if (end_of_sequence) begin
              state     <= REPORT;
              res_valid <= 1'b1;
              res_match <= 1'b0;
              res_index <= 2'd0;
              res_error <= ERR_SHORT;
              res_data  <= {shift_reg[126:0], in_data};
            end
          end
`ifdef STREAM_MATCH_TIMEOUT_EN
          else if (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= REPORT;
            res_valid <= 1'b1;
            res_match <= 1'b0;
            res_index <= 2'd0;
            res_error <= ERR_TIMEOUT;
            res_data  <= shift_reg;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
`endif
        end

        COMPARE: begin
          // Ascending scan means the lowest matching index always wins.
          if (shift_reg == key_sel) begin
            state     <= REPORT;
            res_valid <= 1'b1;
            res_match <= 1'b1;
            res_index <= key_idx;
            res_error <= ERR_OK;
            res_data  <= shift_reg;
          end else if (key_idx == 2'd3) begin
            state     <= REPORT;
            res_valid <= 1'b1;
            res_match <= 1'b0;
            res_index <= 2'd0;
            res_error <= ERR_OK;
            res_data  <= shift_reg;
          end else begin
            key_idx <= key_idx + 2'd1;
          end
        end

        REPORT: begin
          if (res_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/stream_match_ctrl.md
# stream_match_ctrl

Sequencing controller for the serial-to-128-bit parse/compare datapath. Frames a serial bit stream into one 128-bit word and compares it one key per cycle against four prestored 128-bit constants. Reports the match result through a valid/ready handshake. Sits between the serial input front end and the downstream crypto/key-handling logic.

## Interface
- KEY0, 128'h0123456789ABCDEF0123456789ABCDEF, prestored key index 0
- KEY1, 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF, prestored key index 1
- KEY2, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, prestored key index 2
- KEY3, 128'h00000000000000000000000000000000, prestored key index 3
- TIMEOUT_CYCLES, 255, idle-gap limit while shifting; used only when the timeout feature is compiled in
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  begin a frame; sampled only in IDLE
- in_valid  input  1  in_data carries a valid bit this cycle
- in_data  input  1  serial data bit, MSB first
- end_of_sequence  input  1  sender marks the last bit; qualified by in_valid
- busy  output  1  high in every state except IDLE
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts the result
- res_match  output  1  captured word equals a key
- res_index  output  2  lowest matching key index; 0 if no match
- res_error  output  2  00 ok, 01 short frame, 10 timeout
- res_data  output  128  captured word

## Operation
- States:
  - IDLE: start=1 → SHIFT; bit counter and shift register cleared.
  - SHIFT: on each in_valid, shift_reg <= {shift_reg[126:0], in_data} and increment the 7-bit counter. The first bit ends in bit 127.
    - Accepting bit 128 (counter==127) → COMPARE. end_of_sequence on that bit is optional and has no effect.
    - in_valid & end_of_sequence with counter<127 → REPORT with res_error=01 and res_match=0. res_data holds the partial word, right-aligned as shifted.
    - in_valid=0 → hold.
  - COMPARE: compare shift_reg against the key selected by a 2-bit index, one key per cycle, starting at 0.
    - On equality: res_match=1, res_index=index → REPORT.
    - After index 3 with no equality: res_match=0, res_index=0 → REPORT.
  - REPORT: res_valid=1. Hold all res_* stable until res_valid & res_ready, then → IDLE the next cycle.
- Bits arriving outside SHIFT are ignored. start outside IDLE is ignored.
- If a word matches several keys (not possible with the default keys), the lowest index wins.
- res_* are registered and change only on entry to REPORT.

## Timing
- Reset values: busy=0, res_valid=0, res_match=0, res_index=0, res_error=00, res_data=0. Internal state is IDLE, counter=0, shift_reg=0.
- Cycle S (start sampled in IDLE): SHIFT is active from S+1, and the first bit can be accepted at S+1.
- Last bit accepted at cycle T:
  - Key k is compared at T+1+k.
  - On a match at key k, res_valid rises at T+2+k.
  - With no match, res_valid rises at T+5.
- Short frame ending at cycle T: res_valid at T+1.
- Handshake:
  - res_valid never drops without res_ready.
  - res_ready may be high before res_valid; the transfer then completes the first cycle res_valid is high.
  - busy falls the cycle after the transfer.
  - A start asserted in the transfer cycle is ignored; it must be held or reissued in IDLE.
- rst_n low at any time, including mid-SHIFT, mid-COMPARE or in REPORT: immediate return to reset values with no result emitted. Deassertion is synchronous to clk via the usual two-flop release.

## Configuration
- STREAM_MATCH_TIMEOUT_EN defined:
  - A gap counter in SHIFT counts consecutive cycles with in_valid=0 and resets on each valid bit.
  - Reaching TIMEOUT_CYCLES → REPORT with res_error=10, res_match=0, res_data = the partial word.
- Not defined: the gap counter is absent, SHIFT waits indefinitely, res_error never takes 10, and TIMEOUT_CYCLES is unused.

## Test plan
- Reset: assert rst_n=0 mid-SHIFT after 40 bits → all outputs 0 immediately. A following full frame of KEY1 → res_match=1, res_index=1, res_error=00.
- Frame of KEY0 with res_ready held 1 → res_valid at T+2 for exactly one cycle, res_index=0, res_data=KEY0.
- Frame of KEY3 (all zeros) with res_ready=0 for 10 cycles → res_valid rises at T+5, res_* hold stable for 10 cycles, and transfer completes when res_ready=1.
- Frame 128'h5555…55 → no match: res_valid at T+5, res_match=0, res_index=0, res_error=00.
- end_of_sequence on bit 64 of a stream of ones → res_error=01, res_match=0, res_data=64'hFFFF_FFFF_FFFF_FFFF in the low half. start during REPORT is ignored.
- With STREAM_MATCH_TIMEOUT_EN and TIMEOUT_CYCLES=8: 20 bits, then in_valid=0 → res_error=10 on the 8th idle cycle. Without the macro, the same stimulus leaves busy=1 and res_valid=0 indefinitely.
